// File: rtl/fifo_pattern_wr.sv
// FIFO write-side traffic generator: pushes a selectable data pattern
// (increment, Galois LFSR, walking one, constant) into a FIFO write port,
// either continuously or in fixed-length bursts, and reports progress.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | stopped; configuration inputs are captured every cycle
// S_WAIT_EMPTY | armed; waits for the FIFO to drain before a burst starts
// S_WRITE    | writing one word per cycle whenever the FIFO is not full
// S_DONE     | single cycle after the last word of a burst; burst_done=1
module fifo_pattern_wr #(
  parameter int                 DATA_W    = 8,
  parameter int                 LEN_W     = 9,
  parameter logic [DATA_W-1:0]  LFSR_TAPS = 8'hB8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] seed,
  input  logic              wr_full,
  input  logic              wr_empty,
  output logic              wr_req,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              burst_done,
  output logic [LEN_W-1:0]  word_cnt
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_EMPTY = 2'd1,
    S_WRITE      = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic                done_q;

  logic                accept;
  logic [LEN_W-1:0]    cnt_inc;
  logic [DATA_W-1:0]   init_val;
  logic [DATA_W-1:0]   next_val;

  assign accept  = (state_q == S_WRITE) & ~wr_full;
  assign cnt_inc = cnt_q + LEN_W'(1);

  // First word of a burst; an all-zero LFSR would lock up, so it starts at 1.
  always_comb begin
    init_val = seed_q;
    case (mode_q)
      2'd1:    init_val = (seed_q == '0) ? DATA_W'(1) : seed_q;
      2'd2:    init_val = DATA_W'(1);
      default: init_val = seed_q;
    endcase
  end

  // Pattern successor of the word currently on wr_data.
  always_comb begin
    next_val = data_q;
    case (mode_q)
      2'd0: next_val = data_q + DATA_W'(1);
      2'd1: next_val = data_q[0] ? ((data_q >> 1) ^ LFSR_TAPS) : (data_q >> 1);
      2'd2: next_val = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
      default: next_val = data_q;
    endcase
  end

  // Next-state logic; enable=0 takes priority over burst completion.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    len_d   = len_q;
    seed_d  = seed_q;
    case (state_q)
      S_IDLE: begin
        mode_d = mode;
        len_d  = burst_len;
        seed_d = seed;
        if (enable) state_d = S_WAIT_EMPTY;
      end
      S_WAIT_EMPTY: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (wr_empty) begin
          state_d = S_WRITE;
          data_d  = init_val;
          cnt_d   = '0;
        end
      end
      S_WRITE: begin
        if (accept) begin
          data_d = next_val;
          cnt_d  = cnt_inc;
        end
        if (!enable) begin
          state_d = S_IDLE;
        end else if (accept && (len_q != '0) && (cnt_inc == len_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = enable ? S_WAIT_EMPTY : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pattern, counter and shadow configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      done_q  <= (state_d == S_DONE);
    end
  end

  assign wr_req     = accept;
  assign wr_data    = data_q;
  assign word_cnt   = cnt_q;
  assign busy       = (state_q != S_IDLE);
  assign burst_done = done_q;

endmodule

// File: doc/fifo_pattern_wr.md
Name: fifo_pattern_wr

Overview:
- Parametrised FIFO write-side traffic generator; the next generation of the team's single-mode 8-bit counter writer.
- Drives the write port of a dual-clock or single-clock FIFO IP with selectable data patterns and an optional fixed burst length.
- Reports progress to a controller or test harness through status outputs.
- Sits on the FIFO write clock domain, next to the matching read-side checker.

Parameters:
DATA_W, 8, width of wr_data and seed
LEN_W, 9, width of burst_len and word_cnt
LFSR_TAPS, 8'hB8, Galois LFSR feedback mask (DATA_W bits)

Ports:
clk  input  1  write-domain clock
rst_n  input  1  reset; asynchronous, active-low
enable  input  1  level; 1 = run generator
mode  input  2  pattern: 0 incr, 1 LFSR, 2 walking-one, 3 constant
burst_len  input  LEN_W  words per burst; 0 = continuous
seed  input  DATA_W  start value of pattern
wr_full  input  1  FIFO full flag
wr_empty  input  1  FIFO empty flag
wr_req  output  1  FIFO write request
wr_data  output  DATA_W  FIFO write data, registered
busy  output  1  state != IDLE
burst_done  output  1  one-cycle pulse at burst completion
word_cnt  output  LEN_W  accepted writes in current burst

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; wr_data=0; word_cnt=0; burst_done=0; busy=0; wr_req=0.
- "Accepted write" = cycle with wr_req=1 at posedge clk.
- wr_req = (state==WRITE) & ~wr_full, combinational. It never asserts while wr_full=1, including the cycle full rises.
- IDLE:
  - enable=1 -> WAIT_EMPTY.
  - Latch mode, burst_len and seed into shadow registers. Input changes are ignored until the next IDLE.
- WAIT_EMPTY:
  - enable=0 -> IDLE.
  - wr_empty=1 -> WRITE.
  - On the same edge, wr_data <= initial value and word_cnt <= 0.
  - Initial value: seed for modes 0 and 3; seed, or 1 if seed==0, for mode 1; 1 for mode 2.
- WRITE:
  - On each accepted write, wr_data advances and word_cnt increments.
  - Mode 0: +1 mod 2^DATA_W.
  - Mode 1: Galois shift right. If LSB=1, XOR LFSR_TAPS after the shift.
  - Mode 2: rotate left by 1.
  - Mode 3: unchanged.
  - No accepted write (full) -> wr_data and word_cnt hold.
- Burst end (burst_len!=0):
  - When the accepted write makes word_cnt reach burst_len -> DONE.
  - Exactly burst_len words are written.
  - word_cnt saturates at burst_len.
- Continuous (burst_len==0):
  - Never leaves WRITE on count; stalls while full and resumes with the next pattern value when not full.
  - word_cnt wraps mod 2^LEN_W.
- enable=0 sampled in WRITE -> IDLE next cycle, no burst_done. A write accepted on that same edge counts. word_cnt and wr_data hold.
- DONE (one cycle):
  - burst_done=1 and wr_req=0.
  - Next state WAIT_EMPTY if enable=1, else IDLE. A new burst starts only after the FIFO drains to empty.
  - DONE does not re-latch configuration; the new burst restarts the pattern from its initial value.
- Simultaneous: last-word cycle with wr_full=1 means no accept and no DONE; the block waits.
- wr_empty in WRITE is ignored.
- Reset asserted mid-burst forces reset values immediately. After release, the block restarts from IDLE.
- burst_done is registered, high only in DONE.

Test Plan:
- Reset release, enable=1, mode=0, seed=8'h10, burst_len=4, FIFO empty, never full -> wr_req high 4 cycles, data 10,11,12,13; burst_done pulses one cycle after 13; word_cnt=4.
- mode=1, seed=0, burst_len=3 -> data 01, B8, 5C; seed-zero lockup avoided.
- mode=0, burst_len=0, wr_full forced high 3 cycles after the 2nd word -> wr_req=0 during full and the next value follows with no gap or skip. Also seed=8'hFE -> FE, FF, 00 wrap.
- mode=2, burst_len=10 -> 01,02,04,...,80,01,02; then FIFO held non-empty after DONE -> stays in WAIT_EMPTY with wr_req=0 until wr_empty=1.
- enable dropped after the 2nd accepted word of a burst of 8 -> IDLE next cycle, no burst_done, busy=0; mode/seed changed while busy are ignored until re-enable.
- rst_n asserted asynchronously mid-WRITE (between edges) -> wr_req, wr_data, busy drop immediately; re-enable restarts the pattern from seed.
